approx_mult_err_monitor: RTL and testbench

- Downstream consumer of the unsigned 8x8 approximate multipliers (l=6 family).
- Receives each operand pair (x, y) with the approximate product z. Computes the exact product internally and the error distance ED = |x*y - z|.
- Accumulates error statistics over a programmed sample window: sum of ED, max ED, count of erroneous samples.
- Used as the on-chip error-metric collector for the approximate multiplier datapath.

---
 rtl/approx_mult_err_monitor.sv | 199 +++++++++++++++++++
 tb/tb_approx_mult_err_monitor.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_err_monitor.sv
// Error-metric collector for an 8x8 approximate multiplier: ED = |x*y - z| statistics over a window.
// Optional squared-ED accumulator is built when the macro ERR_SQ_EN is defined.
module approx_mult_err_monitor #(
  parameter int CNT_W = 16,
  parameter int SUM_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       x,
  input  logic [7:0]       y,
  input  logic [15:0]      z,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] sum_ed,
  output logic [15:0]      max_ed,
  output logic [CNT_W-1:0] err_cnt,
  output logic             overflow,
  output logic [31:0]      sum_sq,
  output logic [1:0]       state_dbg
);

  // Handshake: a sample moves when in_valid && in_ready at a rising clk edge;
  // in_ready depends only on registered state, never on in_valid.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             s1_valid_q, s1_valid_d;
  logic [15:0]      s1_prod_q, s1_prod_d;
  logic [15:0]      s1_z_q, s1_z_d;
  logic             s2_valid_q, s2_valid_d;
  logic [15:0]      s2_ed_q, s2_ed_d;
  logic [SUM_W-1:0] sum_ed_q, sum_ed_d;
  logic [15:0]      max_ed_q, max_ed_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             overflow_q, overflow_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic [16:0]      diff;
  logic [SUM_W:0]   sum_ext;
`ifdef ERR_SQ_EN
  logic [31:0]      s2_sq_q, s2_sq_d;
  logic [31:0]      sum_sq_q, sum_sq_d;
  logic [32:0]      sq_ext;
`endif

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    acc_d      = acc_q;
    sum_ed_d   = sum_ed_q;
    max_ed_d   = max_ed_q;
    err_cnt_d  = err_cnt_q;
    overflow_d = overflow_q;
    s1_prod_d  = s1_prod_q;
    s1_z_d     = s1_z_q;
    sum_ext    = '0;
`ifdef ERR_SQ_EN
    sum_sq_d   = sum_sq_q;
    sq_ext     = '0;
`endif

    // Stage 1: exact product
    s1_valid_d = accept;
    if (accept) begin
      s1_prod_d = 16'(x) * 16'(y);
      s1_z_d    = z;
    end

    // Stage 2: error distance; z above the exact product gives a negative 17-bit diff
    s2_valid_d = s1_valid_q;
    diff       = {1'b0, s1_prod_q} - {1'b0, s1_z_q};
    s2_ed_d    = diff[16] ? (s1_z_q - s1_prod_q) : diff[15:0];
`ifdef ERR_SQ_EN
    s2_sq_d    = {16'b0, s2_ed_d} * {16'b0, s2_ed_d};
`endif

    // Stage 3: statistics
    if (s2_valid_q) begin
      sum_ext = {1'b0, sum_ed_q} + {{(SUM_W + 1 - 16){1'b0}}, s2_ed_q};
      if (sum_ext[SUM_W]) begin
        sum_ed_d   = '1;
        overflow_d = 1'b1;
      end else begin
        sum_ed_d = sum_ext[SUM_W-1:0];
      end
      if (s2_ed_q > max_ed_q) max_ed_d = s2_ed_q;
      if (s2_ed_q != 16'd0) err_cnt_d = err_cnt_q + CNT_W'(1);
`ifdef ERR_SQ_EN
      sq_ext = {1'b0, sum_sq_q} + {1'b0, s2_sq_q};
      if (sq_ext[32]) begin
        sum_sq_d   = '1;
        overflow_d = 1'b1;
      end else begin
        sum_sq_d = sq_ext[31:0];
      end
`endif
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          num_d      = num_samples;
          acc_d      = '0;
          sum_ed_d   = '0;
          max_ed_d   = '0;
          err_cnt_d  = '0;
          overflow_d = 1'b0;
`ifdef ERR_SQ_EN
          sum_sq_d   = '0;
`endif
          state_d    = (num_samples == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          acc_d = acc_q + CNT_W'(1);
          if (acc_d == num_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!s1_valid_q && !s2_valid_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_RUN) && (acc_d < num_d);
    busy_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      num_q      <= '0;
      acc_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_z_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_ed_q    <= '0;
      sum_ed_q   <= '0;
      max_ed_q   <= '0;
      err_cnt_q  <= '0;
      overflow_q <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef ERR_SQ_EN
      s2_sq_q    <= '0;
      sum_sq_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      acc_q      <= acc_d;
      s1_valid_q <= s1_valid_d;
      s1_prod_q  <= s1_prod_d;
      s1_z_q     <= s1_z_d;
      s2_valid_q <= s2_valid_d;
      s2_ed_q    <= s2_ed_d;
      sum_ed_q   <= sum_ed_d;
      max_ed_q   <= max_ed_d;
      err_cnt_q  <= err_cnt_d;
      overflow_q <= overflow_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef ERR_SQ_EN
      s2_sq_q    <= s2_sq_d;
      sum_sq_q   <= sum_sq_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sum_ed    = sum_ed_q;
  assign max_ed    = max_ed_q;
  assign err_cnt   = err_cnt_q;
  assign overflow  = overflow_q;
  assign state_dbg = state_q;
`ifdef ERR_SQ_EN
  assign sum_sq    = sum_sq_q;
`else
  assign sum_sq    = 32'd0;
`endif

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Bench for approx_mult_err_monitor: directed windows plus randomized windows against an ED-queue model.
module tb_approx_mult_err_monitor;
  localparam int CNT_W = 16;
  localparam int SUM_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       x;
  logic [7:0]       y;
  logic [15:0]      z;
  logic             busy;
  logic             done;
  logic [SUM_W-1:0] sum_ed;
  logic [15:0]      max_ed;
  logic [CNT_W-1:0] err_cnt;
  logic             overflow;
  logic [31:0]      sum_sq;
  logic [1:0]       state_dbg;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [15:0] exp_q[$];

  approx_mult_err_monitor #(.CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .z(z),
    .busy(busy), .done(done), .sum_ed(sum_ed), .max_ed(max_ed),
    .err_cnt(err_cnt), .overflow(overflow), .sum_sq(sum_sq), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_ed(input logic [7:0] a, input logic [7:0] b, input logic [15:0] c);
    int d;
    d = int'(a) * int'(b) - int'(c);
    if (d < 0) d = -d;
    return 16'(d);
  endfunction

  // driver tasks
  task automatic start_window(input int n);
    start       = 1'b1;
    num_samples = CNT_W'(n);
    tick();
    start       = 1'b0;
    exp_q.delete();
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] c);
    in_valid = 1'b1;
    x = a;
    y = b;
    z = c;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        exp_q.push_back(ref_ed(a, b, c));
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (done) return;
      tick();
    end
    check("done_timeout", 64'd0, 64'd1);
  endtask

  // scoreboard: fold the window's expected EDs into the statistics
  task automatic check_stats(input string tag);
    longint s = 0;
    longint sq = 0;
    longint smax = (64'd1 << SUM_W) - 1;
    int     mx = 0;
    int     ec = 0;
    bit     ov = 1'b0;
    foreach (exp_q[i]) begin
      s = s + exp_q[i];
      if (s > smax) begin
        s  = smax;
        ov = 1'b1;
      end
      sq = sq + longint'(exp_q[i]) * longint'(exp_q[i]);
      if (sq > 64'hFFFF_FFFF) begin
        sq = 64'hFFFF_FFFF;
`ifdef ERR_SQ_EN
        ov = 1'b1;
`endif
      end
      if (int'(exp_q[i]) > mx) mx = exp_q[i];
      if (exp_q[i] != 16'd0) ec++;
    end
`ifndef ERR_SQ_EN
    sq = 0;
`endif
    check({tag, "_sum_ed"}, sum_ed, s);
    check({tag, "_max_ed"}, max_ed, mx);
    check({tag, "_err_cnt"}, err_cnt, ec);
    check({tag, "_overflow"}, overflow, ov);
    check({tag, "_sum_sq"}, sum_sq, sq);
  endtask

  task automatic rand_sample(output logic [7:0] a, output logic [7:0] b, output logic [15:0] c);
    int p;
    int v;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    p = int'(a) * int'(b);
    case ($urandom_range(0, 3))
      0: v = p;
      1: v = p + int'($urandom_range(0, 300));
      2: v = p - int'($urandom_range(0, 300));
      default: v = int'($urandom_range(0, 65535));
    endcase
    if (v < 0) v = 0;
    if (v > 65535) v = 65535;
    c = 16'(v);
  endtask

  initial begin
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] rc;
    int          acc;
    bit          chk_next;

    rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
    x = '0; y = '0; z = '0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    tick();
    exp_q.delete();
    check_stats("rst");

    // directed window with latency checks
    start_window(4);
    send(8'd255, 8'd255, 16'd65025);
    send(8'd3, 8'd5, 16'd15);
    send(8'd10, 8'd10, 16'd96);
    send(8'd255, 8'd255, 16'd65000);  // now at t+1
    check("dir_ready_drop", in_ready, 0);
    check("dir_busy", busy, 1);
    tick(); tick();                    // t+3
    check("dir_done_t3", done, 0);
    check("dir_sum_t3", sum_ed, 29);
    tick();                            // t+4
    check("dir_done_t4", done, 1);
    check("dir_busy_done", busy, 0);
    check_stats("dir");
    check("dir_sum_const", sum_ed, 29);
    check("dir_max_const", max_ed, 25);

    // over-approximation
    start_window(1);
    send(8'd0, 8'd0, 16'd100);
    wait_done(10);
    check_stats("overapprox");

    // backpressure: in_valid held for 5 cycles
    start_window(2);
    acc = 0;
    chk_next = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (chk_next) begin
        check("bp_ready_drop", in_ready, 0);
        chk_next = 1'b0;
      end
      rand_sample(ra, rb, rc);
      x = ra; y = rb; z = rc;
      if (in_ready) begin
        acc++;
        exp_q.push_back(ref_ed(ra, rb, rc));
        if (acc == 2) chk_next = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepts", acc, 2);
    wait_done(10);
    check("bp_done", done, 1);
    check("bp_busy", busy, 0);
    check_stats("bp");

    // empty window
    start_window(0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_in_ready", in_ready, 0);
    check_stats("zero");

    // start while busy is ignored
    start_window(3);
    rand_sample(ra, rb, rc);
    send(ra, rb, rc);
    start = 1'b1;
    num_samples = CNT_W'(7);
    rand_sample(ra, rb, rc);
    send(ra, rb, rc);
    start = 1'b0;
    rand_sample(ra, rb, rc);
    send(ra, rb, rc);
    check("busy_start_ready", in_ready, 0);
    wait_done(10);
    check("busy_start_done", done, 1);
    check_stats("busy_start");

    // saturation of the 16-bit accumulator
    start_window(2);
    send(8'd255, 8'd255, 16'd0);
    send(8'd255, 8'd255, 16'd0);
    wait_done(10);
    check_stats("sat");
    check("sat_ovf_const", overflow, 1);
    start_window(1);
    check("sat_ovf_clear", overflow, 0);
    check("sat_sum_clear", sum_ed, 0);
    send(8'd7, 8'd9, 16'd60);
    wait_done(10);
    check_stats("post_sat");

    // randomized windows with random gaps
    for (int w = 0; w < 12; w++) begin
      int n;
      n = $urandom_range(1, 8);
      start_window(n);
      for (int k = 0; k < n; k++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        rand_sample(ra, rb, rc);
        send(ra, rb, rc);
      end
      wait_done(10);
      check("rnd_done", done, 1);
      check_stats("rnd");
    end

    // reset mid-window after 3 accepts
    start_window(6);
    for (int k = 0; k < 3; k++) begin
      rand_sample(ra, rb, rc);
      send(ra, rb, rc);
    end
    rst = 1'b1;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_in_ready", in_ready, 0);
    exp_q.delete();
    check_stats("mid_rst");
    rst = 1'b0;
    tick();
    check("mid_rst_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
